// File: rtl/ifu_bpu.sv
// Fetch-side branch predictor: 2-bit BHT (or static BTFN), return-address stack,
// and a small jalr operand FSM that stalls decode until rs1 can be read.
module ifu_bpu #(
  parameter int PC_SIZE     = 32,
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int RAS_DEPTH   = 4,
  parameter int BHT_EN      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_SIZE-1:0] pc,
  input  logic               dec_i_valid,
  input  logic               dec_jal,
  input  logic               dec_jalr,
  input  logic               dec_bxx,
  input  logic [XLEN-1:0]    dec_bjp_imm,
  input  logic [4:0]         dec_jalr_rs1idx,
  input  logic [4:0]         dec_rdidx,
  input  logic               rs1_dep,
  input  logic               ir_valid_clr,
  input  logic [XLEN-1:0]    rf2bpu_x1,
  input  logic [XLEN-1:0]    rf2bpu_rs1,
  input  logic               upd_valid,
  input  logic [PC_SIZE-1:0] upd_pc,
  input  logic               upd_taken,
  input  logic               flush,
  output logic               prdt_taken,
  output logic [PC_SIZE-1:0] prdt_pc_add_op1,
  output logic [PC_SIZE-1:0] prdt_pc_add_op2,
  output logic               bpu_wait,
  output logic               bpu2rf_rs1_ena
);

  localparam int IW = $clog2(BHT_ENTRIES);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(RAS_DEPTH);

  typedef enum logic [1:0] {IDLE, DEP, RDRF} state_t;

  state_t state, state_nxt;

  // ---------------- branch history table ----------------
  logic [1:0]    bht [BHT_ENTRIES];
  logic [IW-1:0] rd_idx, up_idx;
  logic [1:0]    bht_rd, bht_up;
  logic          pred;

  assign rd_idx = pc[IW+1:2];
  assign up_idx = upd_pc[IW+1:2];
  assign bht_rd = bht[rd_idx];
  assign bht_up = bht[up_idx];
  assign pred   = (BHT_EN != 0) ? bht_rd[1] : dec_bjp_imm[XLEN-1];

  assign prdt_taken      = dec_jal | dec_jalr | (dec_bxx & pred);
  assign prdt_pc_add_op2 = dec_bjp_imm[PC_SIZE-1:0];

  // NOTE: sequential state uses <= so every flop samples pre-edge values; the
  // combinational read above therefore sees the pre-update counter on a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (upd_valid) begin
      if (upd_taken && bht_up != 2'b11)       bht[up_idx] <= bht_up + 2'd1;
      else if (!upd_taken && bht_up != 2'b00) bht[up_idx] <= bht_up - 2'd1;
    end
  end

  // ---------------- return address stack ----------------
  logic [PC_SIZE-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]      ras_ptr;   // next write slot; oldest entry once full
  logic [PW:0]        ras_cnt;
  logic               ras_empty;
  logic [PC_SIZE-1:0] ras_top, ret_addr;
  logic               rs1_x0, rs1_x1, rs1_link, rd_link;
  logic               accept, push, pop;

  assign ras_empty = (ras_cnt == '0);
  assign ras_top   = ras[ras_ptr - PTR_ONE];
  assign ret_addr  = pc + PC_SIZE'(4);

  assign rs1_x0   = (dec_jalr_rs1idx == 5'd0);
  assign rs1_x1   = (dec_jalr_rs1idx == 5'd1);
  assign rs1_link = rs1_x1 | (dec_jalr_rs1idx == 5'd5);
  assign rd_link  = (dec_rdidx == 5'd1) | (dec_rdidx == 5'd5);

  assign accept = dec_i_valid & ~bpu_wait & ~flush;
  assign push   = accept & (dec_jal | dec_jalr) & rd_link;
  assign pop    = accept & dec_jalr & rs1_link & ~rd_link;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (push && !(pop && !ras_empty)) begin
      ras_ptr <= ras_ptr + PTR_ONE;
      if (ras_cnt != CNT_FULL) ras_cnt <= ras_cnt + CNT_ONE;
    end else if (pop && !push && !ras_empty) begin
      ras_ptr <= ras_ptr - PTR_ONE;
      ras_cnt <= ras_cnt - CNT_ONE;
    end
  end

  // NOTE: the stack storage has no reset; entries are only read when ras_cnt
  // says they were written, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (push) ras[(pop && !ras_empty) ? ras_ptr - PTR_ONE : ras_ptr] <= ret_addr;
  end

  // ---------------- jalr operand FSM ----------------
  logic jalr_rf;
  assign jalr_rf = dec_i_valid & dec_jalr & ((~rs1_x0 & ~rs1_x1) | (rs1_x1 & ras_empty));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_nxt      = state;
    bpu_wait       = 1'b0;
    bpu2rf_rs1_ena = 1'b0;
    if (!rst || flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (jalr_rf) begin
          if (rs1_dep) begin
            state_nxt = DEP;
            bpu_wait  = 1'b1;
          end else if (!rs1_x1) begin
            state_nxt      = RDRF;
            bpu_wait       = 1'b1;
            bpu2rf_rs1_ena = 1'b1;
          end
        end
        DEP: begin
          bpu_wait = 1'b1;
          if (ir_valid_clr || !rs1_dep) begin
            state_nxt      = RDRF;
            bpu2rf_rs1_ena = 1'b1;
          end
        end
        RDRF:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    prdt_pc_add_op1 = rf2bpu_rs1[PC_SIZE-1:0];
    if (dec_jal || dec_bxx) begin
      prdt_pc_add_op1 = pc;
    end else if (dec_jalr) begin
      if (rs1_x0)              prdt_pc_add_op1 = '0;
      else if (state == RDRF)  prdt_pc_add_op1 = rf2bpu_rs1[PC_SIZE-1:0];
      else if (rs1_x1)         prdt_pc_add_op1 = ras_empty ? rf2bpu_x1[PC_SIZE-1:0] : ras_top;
    end
  end

  // Bits that only some parameterisations consume.
  logic unused;
  assign unused = ^{upd_pc, dec_bjp_imm, rf2bpu_x1, rf2bpu_rs1, bht_rd};

endmodule

// File: tb/tb_ifu_bpu.sv
// Bench for ifu_bpu: directed scenarios plus randomized traffic, all checked
// each cycle against a queue/array reference model of the predictor.
module tb_ifu_bpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, dec_bjp_imm, rf2bpu_x1, rf2bpu_rs1, upd_pc;
  logic        dec_i_valid, dec_jal, dec_jalr, dec_bxx;
  logic [4:0]  dec_jalr_rs1idx, dec_rdidx;
  logic        rs1_dep, ir_valid_clr, upd_valid, upd_taken, flush;

  logic        prdt_taken, bpu_wait, bpu2rf_rs1_ena;
  logic [31:0] op1, op2;
  logic        taken_s, wait_s, ena_s;
  logic [31:0] op1_s, op2_s;

  always #5 clk = ~clk;

  ifu_bpu #(.BHT_EN(1)) dut (
    .clk(clk), .rst(rst), .pc(pc), .dec_i_valid(dec_i_valid), .dec_jal(dec_jal),
    .dec_jalr(dec_jalr), .dec_bxx(dec_bxx), .dec_bjp_imm(dec_bjp_imm),
    .dec_jalr_rs1idx(dec_jalr_rs1idx), .dec_rdidx(dec_rdidx), .rs1_dep(rs1_dep),
    .ir_valid_clr(ir_valid_clr), .rf2bpu_x1(rf2bpu_x1), .rf2bpu_rs1(rf2bpu_rs1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .flush(flush),
    .prdt_taken(prdt_taken), .prdt_pc_add_op1(op1), .prdt_pc_add_op2(op2),
    .bpu_wait(bpu_wait), .bpu2rf_rs1_ena(bpu2rf_rs1_ena)
  );

  // Static-prediction twin driven by the same stimulus.
  ifu_bpu #(.BHT_EN(0)) dut_s (
    .clk(clk), .rst(rst), .pc(pc), .dec_i_valid(dec_i_valid), .dec_jal(dec_jal),
    .dec_jalr(dec_jalr), .dec_bxx(dec_bxx), .dec_bjp_imm(dec_bjp_imm),
    .dec_jalr_rs1idx(dec_jalr_rs1idx), .dec_rdidx(dec_rdidx), .rs1_dep(rs1_dep),
    .ir_valid_clr(ir_valid_clr), .rf2bpu_x1(rf2bpu_x1), .rf2bpu_rs1(rf2bpu_rs1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .flush(flush),
    .prdt_taken(taken_s), .prdt_pc_add_op1(op1_s), .prdt_pc_add_op2(op2_s),
    .bpu_wait(wait_s), .bpu2rf_rs1_ena(ena_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_bht [64];      // counter value 0..3 per index
  logic [31:0] m_ras [$];       // back = most recent return address
  int          m_stall;         // 0 none, 1 waiting on dependency, 2 reading rs1
  logic        e_taken, e_taken_s, e_wait, e_ena;
  logic [31:0] e_op1;
  int          e_stall_nxt;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_ras.delete();
    m_stall = 0;
  endtask

  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  task automatic settle_check();
    int  bi;
    bit  need_rf;
    if (!rst) model_reset();
    #2;
    bi = int'((pc >> 2) % 64);
    e_taken   = dec_jal | dec_jalr | (dec_bxx & (m_bht[bi] >= 2));
    e_taken_s = dec_jal | dec_jalr | (dec_bxx & ($signed(dec_bjp_imm) < 0));
    if (dec_jal || dec_bxx)                          e_op1 = pc;
    else if (dec_jalr && dec_jalr_rs1idx == 0)       e_op1 = 32'd0;
    else if (dec_jalr && m_stall == 2)               e_op1 = rf2bpu_rs1;
    else if (dec_jalr && dec_jalr_rs1idx == 1)       e_op1 = (m_ras.size() > 0) ? m_ras[$] : rf2bpu_x1;
    else                                             e_op1 = rf2bpu_rs1;
    need_rf = dec_i_valid && dec_jalr &&
              (dec_jalr_rs1idx > 1 || (dec_jalr_rs1idx == 1 && m_ras.size() == 0));
    e_wait = 1'b0; e_ena = 1'b0; e_stall_nxt = 0;
    if (rst && !flush) begin
      if (m_stall == 0) begin
        if (need_rf && rs1_dep) begin
          e_wait = 1'b1; e_stall_nxt = 1;
        end else if (need_rf && dec_jalr_rs1idx != 1) begin
          e_wait = 1'b1; e_ena = 1'b1; e_stall_nxt = 2;
        end
      end else if (m_stall == 1) begin
        e_wait = 1'b1; e_stall_nxt = 1;
        if (ir_valid_clr || !rs1_dep) begin e_ena = 1'b1; e_stall_nxt = 2; end
      end
    end
    check("taken",   prdt_taken,     e_taken);
    check("taken_s", taken_s,        e_taken_s);
    check("op1",     op1,            e_op1);
    check("op2",     op2,            dec_bjp_imm);
    check("wait",    bpu_wait,       e_wait);
    check("rs1_ena", bpu2rf_rs1_ena, e_ena);
  endtask

  task automatic advance();
    bit acc, push, pop;
    int ui;
    if (rst) begin
      acc  = dec_i_valid && !e_wait && !flush;
      push = acc && (dec_jal || dec_jalr) && is_link(dec_rdidx);
      pop  = acc && dec_jalr && is_link(dec_jalr_rs1idx) && !is_link(dec_rdidx);
      if (push && pop && m_ras.size() > 0) m_ras[m_ras.size()-1] = pc + 32'd4;
      else if (push) begin
        if (m_ras.size() == 4) void'(m_ras.pop_front());
        m_ras.push_back(pc + 32'd4);
      end else if (pop && m_ras.size() > 0) void'(m_ras.pop_back());
      if (upd_valid) begin
        ui = int'((upd_pc >> 2) % 64);
        if (upd_taken) m_bht[ui] = (m_bht[ui] < 3) ? m_bht[ui] + 1 : 3;
        else           m_bht[ui] = (m_bht[ui] > 0) ? m_bht[ui] - 1 : 0;
      end
      m_stall = e_stall_nxt;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic instr(input int cls, input logic [31:0] p, input logic [4:0] rs1,
                       input logic [4:0] rd, input logic [31:0] imm);
    dec_i_valid     = (cls != 0);
    dec_jal         = (cls == 1);
    dec_jalr        = (cls == 2);
    dec_bxx         = (cls == 3);
    pc              = p;
    dec_jalr_rs1idx = rs1;
    dec_rdidx       = rd;
    dec_bjp_imm     = imm;
  endtask

  task automatic quiet();
    rs1_dep = 0; ir_valid_clr = 0; upd_valid = 0; upd_taken = 0; upd_pc = 0;
    flush = 0; rf2bpu_x1 = 0; rf2bpu_rs1 = 0;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  logic [31:0] exp_ret [5];
  int          n_wait, n_ena;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    quiet();
    instr(2, 32'h0, 5'd5, 5'd0, 32'h0);   // jalr presented while held in reset
    settle_check();
    check("rst_wait", bpu_wait, 1'b0);
    check("rst_ena",  bpu2rf_rs1_ena, 1'b0);
    advance();
    rst = 1'b1;
    instr(0, 32'h0, 5'd0, 5'd0, 32'h0);
    settle_check(); advance();

    // BHT: read of a colliding update returns the old counter, then saturation.
    instr(3, 32'h8000_0010, 5'd0, 5'd0, 32'h10);
    upd_valid = 1; upd_pc = 32'h8000_0010; upd_taken = 1;
    settle_check();
    check("bht_init", prdt_taken, 1'b0);
    advance();
    settle_check();
    check("bht_one_upd", prdt_taken, 1'b1);
    advance();
    upd_valid = 0;
    settle_check();
    check("bht_two_upd", prdt_taken, 1'b1);
    advance();
    instr(0, 32'h0, 5'd0, 5'd0, 32'h0);
    upd_valid = 1; upd_taken = 0;
    for (int i = 0; i < 4; i++) begin settle_check(); advance(); end
    upd_valid = 0;
    instr(3, 32'h8000_0010, 5'd0, 5'd0, 32'h10);
    settle_check();
    check("bht_down_sat", prdt_taken, 1'b0);
    advance();

    // Static backward-taken prediction.
    instr(3, 32'h8000_0040, 5'd0, 5'd0, -32'sd8);
    settle_check(); check("btfn_back", taken_s, 1'b1); advance();
    instr(3, 32'h8000_0040, 5'd0, 5'd0, 32'd8);
    settle_check(); check("btfn_fwd", taken_s, 1'b0); advance();

    // Call / return through the RAS.
    instr(1, 32'h8000_0000, 5'd0, 5'd1, 32'h100);
    settle_check(); check("jal_op1", op1, 32'h8000_0000); advance();
    instr(2, 32'h8000_0100, 5'd1, 5'd0, 32'h0);
    settle_check(); check("ret_op1", op1, 32'h8000_0004); check("ret_wait", bpu_wait, 1'b0); advance();
    rf2bpu_x1 = 32'h1357_9bdf;
    settle_check(); check("ret_empty", op1, 32'h1357_9bdf); advance();
    rf2bpu_x1 = 0;

    // Overflow: five calls into a four-deep stack, then five returns.
    for (int i = 1; i <= 5; i++) begin
      instr(1, 32'(i * 32'h100), 5'd0, 5'd1, 32'h40);
      settle_check(); advance();
    end
    exp_ret = '{32'h504, 32'h404, 32'h304, 32'h204, 32'h1234_5678};
    rf2bpu_x1 = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      instr(2, 32'h900, 5'd1, 5'd0, 32'h0);
      settle_check(); check($sformatf("ovf_ret%0d", i), op1, exp_ret[i]); advance();
    end
    rf2bpu_x1 = 0;

    // jalr on x5 waiting three cycles on a dependency.
    n_wait = 0; n_ena = 0;
    instr(2, 32'hA00, 5'd5, 5'd0, 32'h8);
    rf2bpu_rs1 = 32'hCAFE_0000;
    for (int c = 0; c < 5; c++) begin
      rs1_dep = (c < 4); ir_valid_clr = (c == 3);
      settle_check();
      n_wait += int'(bpu_wait);
      n_ena  += int'(bpu2rf_rs1_ena);
      if (c == 3) check("dep_ena_cycle", bpu2rf_rs1_ena, 1'b1);
      if (c == 4) check("dep_op1", op1, 32'hCAFE_0000);
      advance();
    end
    check("dep_wait_cycles", 64'(n_wait), 64'd4);
    check("dep_ena_cycles",  64'(n_ena),  64'd1);
    quiet();

    // Flush out of DEP leaves the RAS alone.
    instr(1, 32'h700, 5'd0, 5'd1, 32'h0);
    settle_check(); advance();
    instr(2, 32'hB00, 5'd5, 5'd0, 32'h0);
    rs1_dep = 1;
    settle_check(); check("flush_pre_wait", bpu_wait, 1'b1); advance();
    flush = 1;
    settle_check(); check("flush_wait", bpu_wait, 1'b0); advance();
    flush = 0; rs1_dep = 0;
    instr(2, 32'hB04, 5'd1, 5'd0, 32'h0);
    settle_check(); check("flush_ras", op1, 32'h704); check("flush_idle", bpu_wait, 1'b0); advance();

    // Reset while a jalr sits in DEP.
    instr(1, 32'h900, 5'd0, 5'd1, 32'h0);
    settle_check(); advance();
    instr(2, 32'hC00, 5'd7, 5'd0, 32'h0);
    rs1_dep = 1;
    settle_check(); advance();
    rst = 0;
    settle_check(); check("midrst_wait", bpu_wait, 1'b0); check("midrst_ena", bpu2rf_rs1_ena, 1'b0); advance();
    rst = 1; rs1_dep = 0;
    instr(2, 32'hC04, 5'd1, 5'd0, 32'h0);
    rf2bpu_x1 = 32'h2468_ACE0;
    settle_check(); check("midrst_ras", op1, 32'h2468_ACE0); check("midrst_idle", bpu_wait, 1'b0); advance();
    quiet();

    // Randomized traffic; a stalled instruction is held until it leaves the stall.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) != 0);
      if (m_stall == 0 || !rst) begin
        instr((($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3))),
              32'h8000_0000 + ($urandom_range(0, 15) << 2),
              pick_reg(), pick_reg(), $urandom());
        if ($urandom_range(0, 5) == 0) begin
          dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
        end
      end
      rs1_dep      = ($urandom_range(0, 2) == 0);
      ir_valid_clr = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      upd_valid    = ($urandom_range(0, 4) < 2);
      upd_taken    = $urandom_range(0, 1);
      upd_pc       = 32'h8000_0000 + ($urandom_range(0, 15) << 2);
      rf2bpu_x1    = $urandom();
      rf2bpu_rs1   = $urandom();
      settle_check();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
